rns_alu_mc: RTL

- Multi-channel, multi-cycle RNS-domain ALU for the EX stage. Successor to the single-modulus combinational RNS ALU.
- CHANNELS residue lanes run in lockstep. Each lane has its own modulus, taken from a packed parameter.
- Supports ADD, SUB, MUL and NEG. MUL is an iterative interleaved modular multiplier, so no wide product or `%` operator is needed.
- valid/ready handshakes on both sides. Lanes are independent; no carries pass between them.

---
 rtl/rns_alu_pkg.sv | 27 ++
 rtl/rns_alu_mc_lane.sv | 96 +++++++++
 rtl/rns_alu_mc.sv | 137 +++++++++++++
 3 files changed

// File: rtl/rns_alu_pkg.sv
// Shared types and helpers for the multi-channel RNS ALU (rns_alu_mc).
// Optional MAC support is selected by the RNS_ALU_MAC_EN macro in the design files.
package rns_alu_pkg;

  localparam int unsigned MOD_VEC_W = 256;

  typedef enum logic [1:0] {
    OP_ADD     = 2'b00,
    OP_SUB     = 2'b01,
    OP_MUL     = 2'b10,
    OP_NEG_MAC = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_DONE
  } state_e;

  // Extracts the (width+1)-bit modulus of one lane from the packed moduli vector.
  function automatic logic [31:0] mod_slice(input logic [MOD_VEC_W-1:0] moduli,
                                            input int unsigned lane,
                                            input int unsigned width);
    return 32'(moduli >> (lane * (width + 1))) & ((32'd1 << (width + 1)) - 32'd1);
  endfunction

endpackage

// File: rtl/rns_alu_mc_lane.sv
// One residue lane: pre-reduction, ADD/SUB/NEG, one interleaved modmul step per
// cycle and (with RNS_ALU_MAC_EN) a per-lane accumulator.
module rns_lane_modmul
  import rns_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter logic [WIDTH:0] MOD = 9'd129,
  parameter int unsigned CW = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             do_arith,
  input  logic             do_step,
  input  logic             do_wr_mul,
`ifdef RNS_ALU_MAC_EN
  input  logic             do_fold,
`endif
  input  op_e              op,
  input  logic [CW-1:0]    bit_idx,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] dout
);

  localparam logic [WIDTH+1:0] MODX = {1'b0, MOD};

  logic [WIDTH-1:0] a_q, b_q, acc_q, dout_q;
  logic [WIDTH-1:0] a_red, b_red, arith_r, step_r;
  logic [WIDTH:0]   a_ext, b_ext, sum;
  logic [WIDTH+1:0] dbl, dbl_r, addend, sum2;

  always_comb begin
    a_ext = {1'b0, a_in};
    b_ext = {1'b0, b_in};
    a_red = WIDTH'((a_ext >= MOD) ? a_ext - MOD : a_ext);
    b_red = WIDTH'((b_ext >= MOD) ? b_ext - MOD : b_ext);

    sum = {1'b0, a_q} + {1'b0, b_q};
    case (op)
      OP_ADD:  arith_r = WIDTH'((sum >= MOD) ? sum - MOD : sum);
      OP_SUB:  arith_r = WIDTH'((a_q >= b_q) ? {1'b0, a_q} - {1'b0, b_q}
                                             : {1'b0, a_q} + MOD - {1'b0, b_q});
      default: arith_r = WIDTH'((a_q == '0) ? '0 : MOD - {1'b0, a_q});
    endcase

    // Double then conditionally add a; each half needs one subtraction of m.
    dbl    = {1'b0, acc_q, 1'b0};
    dbl_r  = (dbl >= MODX) ? dbl - MODX : dbl;
    addend = b_q[bit_idx] ? {2'b00, a_q} : '0;
    sum2   = dbl_r + addend;
    step_r = WIDTH'((sum2 >= MODX) ? sum2 - MODX : sum2);
  end

`ifdef RNS_ALU_MAC_EN
  logic [WIDTH-1:0] accum_q, fold_r;
  logic [WIDTH:0]   fsum;

  always_comb begin
    fsum   = {1'b0, accum_q} + {1'b0, acc_q};
    fold_r = WIDTH'((fsum >= MOD) ? fsum - MOD : fsum);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      accum_q <= '0;
    end else if (do_fold) begin
      accum_q <= fold_r;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      acc_q  <= '0;
      dout_q <= '0;
    end else begin
      if (load) begin
        a_q   <= a_red;
        b_q   <= b_red;
        acc_q <= '0;
      end
      if (do_step) acc_q <= step_r;
      if (do_arith) dout_q <= arith_r;
      if (do_wr_mul) dout_q <= step_r;
`ifdef RNS_ALU_MAC_EN
      if (do_fold) dout_q <= fold_r;
`endif
    end
  end

  assign dout = dout_q;

endmodule

// File: rtl/rns_alu_mc.sv
// Multi-channel multi-cycle RNS ALU: shared FSM/counter driving CHANNELS lanes.
// Define RNS_ALU_MAC_EN to turn op 11 from NEG into a per-lane MAC.
module rns_alu_mc
  import rns_alu_pkg::*;
#(
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned WIDTH = 8,
  parameter logic [CHANNELS*(WIDTH+1)-1:0] MODULI = {9'd256, 9'd129}
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [1:0]                op,
  input  logic [CHANNELS*WIDTH-1:0] op1,
  input  logic [CHANNELS*WIDTH-1:0] op2,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CHANNELS*WIDTH-1:0] dout,
  output logic                      busy
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [MOD_VEC_W-1:0] MODVEC = MOD_VEC_W'(MODULI);

  state_e        state_q, state_d;
  op_e           op_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          load, do_arith, do_step, do_wr_mul, mul_path;
`ifdef RNS_ALU_MAC_EN
  logic          fold_q, fold_d, do_fold;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    load      = 1'b0;
    do_arith  = 1'b0;
    do_step   = 1'b0;
    do_wr_mul = 1'b0;
`ifdef RNS_ALU_MAC_EN
    fold_d    = fold_q;
    do_fold   = 1'b0;
    mul_path  = (op_q == OP_MUL) || (op_q == OP_NEG_MAC);
`else
    mul_path  = (op_q == OP_MUL);
`endif
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          load    = 1'b1;
          cnt_d   = CW'(WIDTH - 1);
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (!mul_path) begin
          do_arith = 1'b1;
          state_d  = S_DONE;
        end
`ifdef RNS_ALU_MAC_EN
        else if (fold_q) begin
          do_fold = 1'b1;
          fold_d  = 1'b0;
          state_d = S_DONE;
        end
`endif
        else begin
          do_step = 1'b1;
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
          end else if (op_q == OP_MUL) begin
            do_wr_mul = 1'b1;
            state_d   = S_DONE;
          end
`ifdef RNS_ALU_MAC_EN
          else begin
            fold_d = 1'b1;
          end
`endif
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= OP_ADD;
      cnt_q   <= '0;
`ifdef RNS_ALU_MAC_EN
      fold_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
`ifdef RNS_ALU_MAC_EN
      fold_q  <= fold_d;
`endif
      if (load) op_q <= op_e'(op);
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q == S_EXEC);

  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    localparam logic [31:0] MOD_RAW = mod_slice(MODVEC, c, WIDTH);

    rns_lane_modmul #(
      .WIDTH (WIDTH),
      .MOD   (MOD_RAW[WIDTH:0]),
      .CW    (CW)
    ) u_lane (
      .clk       (clk),
      .rst       (rst),
      .load      (load),
      .do_arith  (do_arith),
      .do_step   (do_step),
      .do_wr_mul (do_wr_mul),
`ifdef RNS_ALU_MAC_EN
      .do_fold   (do_fold),
`endif
      .op        (op_q),
      .bit_idx   (cnt_q),
      .a_in      (op1[c*WIDTH +: WIDTH]),
      .b_in      (op2[c*WIDTH +: WIDTH]),
      .dout      (dout[c*WIDTH +: WIDTH])
    );
  end

endmodule
